// File: rtl/decode_stage_pkg.sv
// Shared RV32I/RV64I decode definitions: base opcodes, instruction formats,
// the per-instruction decoded field bundle and the opcode-to-format map.
package instructionList;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

    // Every supported opcode ends in 2'b11, so a compressed-style low pair falls to ILLEGAL.
    function automatic fmt_e opcode_fmt(input logic [31:0] instr);
        fmt_e f;
        f = FMT_ILLEGAL;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_OP:                       f = FMT_R;
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
                OPC_STORE:                    f = FMT_S;
                OPC_BRANCH:                   f = FMT_B;
                OPC_LUI, OPC_AUIPC:           f = FMT_U;
                OPC_JAL:                      f = FMT_J;
                default:                      f = FMT_ILLEGAL;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bus: input handshake, flush, and the registered decoded outputs.
interface decode_stage_if
    import instructionList::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_in;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] pc_out;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, opcode, funct3, funct7,
               rs1, rs2, rd, imm, fmt, rs1_used, rs2_used, rd_we, illegal
    );

    modport slave (
        input  flush, in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, pc_out, opcode, funct3, funct7,
               rs1, rs2, rd, imm, fmt, rs1_used, rs2_used, rd_we, illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: rebuilds the scattered immediate bits of
// each format and sign-extends to XLEN (R and ILLEGAL yield zero).
module decode_imm_gen
    import instructionList::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_imm_i = i_instr[31:20];
    assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_imm = '0;
        case (i_fmt)
            FMT_I:   o_imm = XLEN'(w_imm_i);
            FMT_S:   o_imm = XLEN'(w_imm_s);
            FMT_B:   o_imm = XLEN'(w_imm_b);
            FMT_U:   o_imm = XLEN'(w_imm_u);
            FMT_J:   o_imm = XLEN'(w_imm_j);
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational field/format/immediate decode feeding
// a single elastic valid/ready output register with stall and flush.
module decode_stage
    import instructionList::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_W        = 32,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave dec
);

    fmt_e            w_fmt;
    dec_fields_t     w_fields;
    logic [XLEN-1:0] w_imm;
    logic            w_shift_imm;
    logic            w_rd_used;
    logic            w_in_ready;
    logic            w_accept;

    logic            r_valid;
    dec_fields_t     r_fields;
    logic [XLEN-1:0] r_imm;
    logic [PC_W-1:0] r_pc;

    assign w_fmt       = opcode_fmt(dec.instr);
    assign w_shift_imm = (dec.instr[6:0] == OPC_OP_IMM)
                       && ((dec.instr[14:12] == F3_SLLI) || (dec.instr[14:12] == F3_SRXI));

    always_comb begin
        w_fields         = '0;
        w_rd_used        = 1'b0;
        w_fields.opcode  = dec.instr[6:0];
        w_fields.fmt     = w_fmt;
        w_fields.illegal = (w_fmt == FMT_ILLEGAL);
        case (w_fmt)
            FMT_R: begin
                w_fields.rs1_used = 1'b1;
                w_fields.rs2_used = 1'b1;
                w_rd_used         = 1'b1;
            end
            FMT_I: begin
                w_fields.rs1_used = 1'b1;
                w_rd_used         = 1'b1;
            end
            FMT_S, FMT_B: begin
                w_fields.rs1_used = 1'b1;
                w_fields.rs2_used = 1'b1;
            end
            FMT_U, FMT_J: begin
                w_rd_used         = 1'b1;
            end
            default: ;
        endcase

        w_fields.funct3 = ((w_fmt == FMT_U) || (w_fmt == FMT_J)) ? 3'b000 : dec.instr[14:12];
        w_fields.funct7 = (!ZERO_UNUSED || (w_fmt == FMT_R) || ((w_fmt == FMT_I) && w_shift_imm))
                        ? dec.instr[31:25] : '0;
        w_fields.rs1    = (!ZERO_UNUSED || w_fields.rs1_used) ? dec.instr[19:15] : '0;
        w_fields.rs2    = (!ZERO_UNUSED || w_fields.rs2_used) ? dec.instr[24:20] : '0;
        w_fields.rd     = (!ZERO_UNUSED || w_rd_used)         ? dec.instr[11:7]  : '0;
        w_fields.rd_we  = w_rd_used && (dec.instr[11:7] != 5'd0);
    end

    decode_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_instr(dec.instr),
        .i_fmt  (w_fmt),
        .o_imm  (w_imm)
    );

    assign w_in_ready = rst_n && !dec.flush && (!r_valid || dec.out_ready);
    assign w_accept   = dec.in_valid && w_in_ready;

    // Priority: reset, then flush (drops a stalled entry), then load, then drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_fields <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
        end else if (dec.flush) begin
            r_valid  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_fields <= w_fields;
            r_imm    <= w_imm;
            r_pc     <= dec.pc_in;
        end else if (dec.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign dec.in_ready  = w_in_ready;
    assign dec.out_valid = r_valid;
    assign dec.pc_out    = r_pc;
    assign dec.opcode    = r_fields.opcode;
    assign dec.funct3    = r_fields.funct3;
    assign dec.funct7    = r_fields.funct7;
    assign dec.rs1       = r_fields.rs1;
    assign dec.rs2       = r_fields.rs2;
    assign dec.rd        = r_fields.rd;
    assign dec.imm       = r_imm;
    assign dec.fmt       = r_fields.fmt;
    assign dec.rs1_used  = r_fields.rs1_used;
    assign dec.rs2_used  = r_fields.rs2_used;
    assign dec.rd_we     = r_fields.rd_we;
    assign dec.illegal   = r_fields.illegal;

endmodule
